// File: rtl/input_collector.sv
// -----------------------------------------------------------------------------
// input_collector
//
// Assembles an LSB-first serial frame into a parallel word and holds it
// until the consumer acknowledges it. A frame is qualified by serial_valid,
// which stays high for the whole frame and may stay high for a while after
// it. Words that complete while an unacknowledged word is still held are
// dropped and flagged with a sticky overrun.
//
// Optional feature (macro RX_PARITY_CHECK_EN):
//   When defined, each frame carries one extra even-parity bit after the
//   data bits. parity_err reports a mismatch for the held word. When the
//   macro is undefined, there is no parity state and parity_err is tied to 0.
//
// Parameters:
//   INPUT_WIDTH  data bits per frame (2..64)
//
// Ports:
//   fast_clk      in   single clock, rising edge
//   reset         in   asynchronous active-low reset
//   serial_valid  in   frame qualifier
//   serial_in     in   serial data bit, LSB first
//   data_ack      in   consumer acknowledge of the held word
//   data_out      out  [INPUT_WIDTH-1:0] held parallel word
//   data_valid    out  data_out holds an unacknowledged word
//   serial_done   out  one-cycle pulse per completed frame (also dropped ones)
//   overrun       out  sticky: a completed frame was dropped
//   parity_err    out  parity mismatch on the held word
// -----------------------------------------------------------------------------
module input_collector #(
    parameter int INPUT_WIDTH = 16
) (
    input  logic                   fast_clk,
    input  logic                   reset,
    input  logic                   serial_valid,
    input  logic                   serial_in,
    input  logic                   data_ack,
    output logic [INPUT_WIDTH-1:0] data_out,
    output logic                   data_valid,
    output logic                   serial_done,
    output logic                   overrun,
    output logic                   parity_err
);

    // One spare bit so the counter can reach INPUT_WIDTH (the parity slot)
    // without wrapping.
    localparam int CNT_W = $clog2(INPUT_WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(INPUT_WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
`ifdef RX_PARITY_CHECK_EN
        ST_PARITY,
`endif
        ST_WAIT_LOW
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic [INPUT_WIDTH-1:0] r_shift;
    logic [INPUT_WIDTH-1:0] w_shift_nxt;
    logic [INPUT_WIDTH-1:0] w_shift_ins;
    logic [INPUT_WIDTH-1:0] w_word;
    logic                   w_complete;

    logic [INPUT_WIDTH-1:0] r_data;
    logic                   r_valid;
    logic                   r_done;
    logic                   r_overrun;

    // Bits above the counter are always zero inside a frame, so OR-ing the
    // new bit in at the counter position is enough.
    assign w_shift_ins = r_shift | ({{(INPUT_WIDTH-1){1'b0}}, serial_in} << r_cnt);

`ifdef RX_PARITY_CHECK_EN
    logic w_perr;
    logic r_perr;
`endif

    // -------------------------------------------------------------------------
    // Frame FSM: state, bit counter and shift register
    // -------------------------------------------------------------------------
    always_ff @(posedge fast_clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_shift <= '0;
        end else begin
            // NOTE: registered state uses non-blocking assignments so every
            // flop samples the pre-edge values, independent of block order.
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_shift <= w_shift_nxt;
        end
    end

    always_comb begin
        // NOTE: every signal gets a default before the case so no path
        // leaves one unassigned, which would otherwise infer a latch.
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_shift_nxt = r_shift;
        w_complete  = 1'b0;
        w_word      = w_shift_ins;
`ifdef RX_PARITY_CHECK_EN
        w_perr      = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (serial_valid) begin
                    w_shift_nxt = {{(INPUT_WIDTH-1){1'b0}}, serial_in};
                    w_cnt_nxt   = CNT_W'(1);
                    w_state_nxt = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                if (!serial_valid) begin
                    // Aborted frame: drop the partial word silently.
                    w_shift_nxt = '0;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_IDLE;
                end else if (r_cnt == LAST_IDX) begin
`ifdef RX_PARITY_CHECK_EN
                    w_shift_nxt = w_shift_ins;
                    w_cnt_nxt   = r_cnt + CNT_W'(1);
                    w_state_nxt = ST_PARITY;
`else
                    w_complete  = 1'b1;
                    w_word      = w_shift_ins;
                    w_shift_nxt = '0;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_WAIT_LOW;
`endif
                end else begin
                    w_shift_nxt = w_shift_ins;
                    w_cnt_nxt   = r_cnt + CNT_W'(1);
                end
            end

`ifdef RX_PARITY_CHECK_EN
            ST_PARITY: begin
                if (!serial_valid) begin
                    w_shift_nxt = '0;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_IDLE;
                end else begin
                    // Even parity: data XOR parity bit must be 0.
                    w_complete  = 1'b1;
                    w_word      = r_shift;
                    w_perr      = (^r_shift) ^ serial_in;
                    w_shift_nxt = '0;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_WAIT_LOW;
                end
            end
`endif

            ST_WAIT_LOW: begin
                // The qualifier may linger after the frame; those cycles
                // must not start a new frame.
                if (!serial_valid) begin
                    w_state_nxt = ST_IDLE;
                end
            end

            default: begin
                w_shift_nxt = '0;
                w_cnt_nxt   = '0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Output holding register and handshake
    // -------------------------------------------------------------------------
    always_ff @(posedge fast_clk or negedge reset) begin
        if (!reset) begin
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_done    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_done <= w_complete;

            // A completion on the same edge as an ack replaces the held word.
            if (w_complete && (!r_valid || data_ack)) begin
                r_data  <= w_word;
                r_valid <= 1'b1;
            end else if (data_ack && r_valid) begin
                r_valid <= 1'b0;
            end

            // overrun can only be set while a word is held, so clearing it on
            // an accepted ack also covers the "until data_ack" rule.
            if (w_complete && r_valid && !data_ack) begin
                r_overrun <= 1'b1;
            end else if (data_ack && r_valid) begin
                r_overrun <= 1'b0;
            end
        end
    end

`ifdef RX_PARITY_CHECK_EN
    always_ff @(posedge fast_clk or negedge reset) begin
        if (!reset) begin
            r_perr <= 1'b0;
        end else if (w_complete && (!r_valid || data_ack)) begin
            r_perr <= w_perr;
        end else if (data_ack && r_valid) begin
            r_perr <= 1'b0;
        end
    end

    assign parity_err = r_perr;
`else
    assign parity_err = 1'b0;
`endif

    assign data_out    = r_data;
    assign data_valid  = r_valid;
    assign serial_done = r_done;
    assign overrun     = r_overrun;

endmodule

// File: tb/tb_input_collector.sv
// -----------------------------------------------------------------------------
// tb_input_collector
//
// Directed bench for input_collector with INPUT_WIDTH=16. Inputs are driven
// on the falling edge and outputs are sampled on the falling edge, half a
// period after the rising edge that updated them. A table of frames covers
// the basic receive/ack path; hand-written sequences cover abort, overrun,
// ack-on-completion, asynchronous reset and (when RX_PARITY_CHECK_EN is
// defined) parity checking.
// -----------------------------------------------------------------------------
module tb_input_collector;

    localparam int W = 16;

    logic         fast_clk;
    logic         reset;
    logic         serial_valid;
    logic         serial_in;
    logic         data_ack;
    logic [W-1:0] data_out;
    logic         data_valid;
    logic         serial_done;
    logic         overrun;
    logic         parity_err;

    int n_vec;
    int n_err;

    input_collector #(.INPUT_WIDTH(W)) dut (
        .fast_clk     (fast_clk),
        .reset        (reset),
        .serial_valid (serial_valid),
        .serial_in    (serial_in),
        .data_ack     (data_ack),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .serial_done  (serial_done),
        .overrun      (overrun),
        .parity_err   (parity_err)
    );

    initial fast_clk = 1'b0;
    always #5 fast_clk = ~fast_clk;

    typedef struct {
        logic [W-1:0] word;
        int           hold;      // extra cycles serial_valid stays high
        logic [W-1:0] exp_data;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drives the first nbits data bits of w, one per cycle. When all data
    // bits are sent and the parity feature is built in, the parity bit
    // follows. Optionally raises data_ack together with the final bit.
    // Returns right after driving the final bit (at a falling edge).
    task automatic send_frame(input logic [W-1:0] w, input logic par,
                              input int nbits, input logic ack_last);
        int total;
        total = nbits;
`ifdef RX_PARITY_CHECK_EN
        if (nbits == W) total = W + 1;
`endif
        for (int i = 0; i < total; i++) begin
            @(negedge fast_clk);
            serial_valid = 1'b1;
            serial_in    = (i < W) ? w[i] : par;
            data_ack     = ack_last && (i == total - 1);
        end
    endtask

    // Even parity bit for a word.
    function automatic logic even_par(input logic [W-1:0] w);
        return ^w;
    endfunction

    // Drop the qualifier and acknowledge; checks the word is released.
    task automatic ack_word(input string name);
        @(negedge fast_clk);
        serial_valid = 1'b0;
        data_ack     = 1'b1;
        @(negedge fast_clk);
        data_ack = 1'b0;
        check({name, "_valid_after_ack"}, 64'(data_valid), 64'd0);
        check({name, "_overrun_after_ack"}, 64'(overrun), 64'd0);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;

        vecs[0] = '{word: 16'hA5C3, hold: 4, exp_data: 16'hA5C3};
        vecs[1] = '{word: 16'h0000, hold: 0, exp_data: 16'h0000};
        vecs[2] = '{word: 16'hFFFF, hold: 1, exp_data: 16'hFFFF};
        vecs[3] = '{word: 16'h8001, hold: 2, exp_data: 16'h8001};
        vecs[4] = '{word: 16'h5555, hold: 0, exp_data: 16'h5555};

        reset        = 1'b0;
        serial_valid = 1'b0;
        serial_in    = 1'b0;
        data_ack     = 1'b0;

        repeat (2) @(negedge fast_clk);
        check("rst_data", 64'(data_out), 64'd0);
        check("rst_valid", 64'(data_valid), 64'd0);
        check("rst_done", 64'(serial_done), 64'd0);
        check("rst_overrun", 64'(overrun), 64'd0);
        check("rst_perr", 64'(parity_err), 64'd0);
        reset = 1'b1;
        repeat (2) @(negedge fast_clk);

        // ---- table-driven frames ------------------------------------------
        foreach (vecs[k]) begin
            send_frame(vecs[k].word, even_par(vecs[k].word), W, 1'b0);
            @(negedge fast_clk);
            check($sformatf("v%0d_data", k), 64'(data_out), 64'(vecs[k].exp_data));
            check($sformatf("v%0d_valid", k), 64'(data_valid), 64'd1);
            check($sformatf("v%0d_done", k), 64'(serial_done), 64'd1);
            check($sformatf("v%0d_perr", k), 64'(parity_err), 64'd0);
            for (int h = 0; h < vecs[k].hold; h++) begin
                serial_in = ~serial_in;
                @(negedge fast_clk);
                check($sformatf("v%0d_hold%0d_done", k, h), 64'(serial_done), 64'd0);
                check($sformatf("v%0d_hold%0d_data", k, h), 64'(data_out), 64'(vecs[k].exp_data));
            end
            ack_word($sformatf("v%0d", k));
            check($sformatf("v%0d_no_second_done", k), 64'(serial_done), 64'd0);
        end

        // ---- abort after bit 7 of 0x1234, then 0xBEEF ---------------------
        send_frame(16'h1234, 1'b0, 8, 1'b0);
        @(negedge fast_clk);
        serial_valid = 1'b0;
        @(negedge fast_clk);
        check("abort_done", 64'(serial_done), 64'd0);
        check("abort_valid", 64'(data_valid), 64'd0);
        send_frame(16'hBEEF, even_par(16'hBEEF), W, 1'b0);
        @(negedge fast_clk);
        check("beef_data", 64'(data_out), 64'hBEEF);
        check("beef_done", 64'(serial_done), 64'd1);
        serial_valid = 1'b0;
        @(negedge fast_clk);
        check("beef_done_once", 64'(serial_done), 64'd0);
        ack_word("beef");

        // ---- overrun: 0x1111 then 0x2222 without ack ----------------------
        send_frame(16'h1111, even_par(16'h1111), W, 1'b0);
        @(negedge fast_clk);
        serial_valid = 1'b0;
        send_frame(16'h2222, even_par(16'h2222), W, 1'b0);
        @(negedge fast_clk);
        check("ovr_data", 64'(data_out), 64'h1111);
        check("ovr_valid", 64'(data_valid), 64'd1);
        check("ovr_flag", 64'(overrun), 64'd1);
        check("ovr_done", 64'(serial_done), 64'd1);
        serial_valid = 1'b0;
        @(negedge fast_clk);
        check("ovr_sticky", 64'(overrun), 64'd1);
        ack_word("ovr");

        // ---- ack on the completion edge of 0x3333 --------------------------
        send_frame(16'h1111, even_par(16'h1111), W, 1'b0);
        @(negedge fast_clk);
        serial_valid = 1'b0;
        send_frame(16'h3333, even_par(16'h3333), W, 1'b1);
        @(negedge fast_clk);
        data_ack = 1'b0;
        check("ackc_data", 64'(data_out), 64'h3333);
        check("ackc_valid", 64'(data_valid), 64'd1);
        check("ackc_overrun", 64'(overrun), 64'd0);
        ack_word("ackc");

        // ---- asynchronous reset mid-frame ---------------------------------
        send_frame(16'h1111, even_par(16'h1111), W, 1'b0);
        @(negedge fast_clk);
        serial_valid = 1'b0;
        send_frame(16'h2222, even_par(16'h2222), W, 1'b0);
        @(negedge fast_clk);
        serial_valid = 1'b0;
        @(negedge fast_clk);
        check("pre_rst_valid", 64'(data_valid), 64'd1);
        check("pre_rst_overrun", 64'(overrun), 64'd1);
        send_frame(16'h7777, 1'b0, 10, 1'b0);
        @(posedge fast_clk);
        #2;
        reset = 1'b0;
        #1;
        check("arst_data", 64'(data_out), 64'd0);
        check("arst_valid", 64'(data_valid), 64'd0);
        check("arst_done", 64'(serial_done), 64'd0);
        check("arst_overrun", 64'(overrun), 64'd0);
        check("arst_perr", 64'(parity_err), 64'd0);
        @(negedge fast_clk);
        serial_valid = 1'b0;
        @(negedge fast_clk);
        reset = 1'b1;
        repeat (2) @(negedge fast_clk);
        send_frame(16'h00FF, even_par(16'h00FF), W, 1'b0);
        @(negedge fast_clk);
        check("post_rst_data", 64'(data_out), 64'h00FF);
        check("post_rst_valid", 64'(data_valid), 64'd1);
        check("post_rst_done", 64'(serial_done), 64'd1);
        ack_word("post_rst");

`ifdef RX_PARITY_CHECK_EN
        // ---- parity checking ----------------------------------------------
        send_frame(16'h0001, 1'b1, W, 1'b0);
        @(negedge fast_clk);
        check("par_good_data", 64'(data_out), 64'h0001);
        check("par_good_err", 64'(parity_err), 64'd0);
        ack_word("par_good");
        send_frame(16'h0001, 1'b0, W, 1'b0);
        @(negedge fast_clk);
        check("par_bad_data", 64'(data_out), 64'h0001);
        check("par_bad_valid", 64'(data_valid), 64'd1);
        check("par_bad_err", 64'(parity_err), 64'd1);
        ack_word("par_bad");
        check("par_err_cleared", 64'(parity_err), 64'd0);
`else
        check("no_par_err", 64'(parity_err), 64'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/input_collector.md
INPUT_COLLECTOR -- requirements
Module: input_collector

Interface
REQ-001 SHALL have parameter INPUT_WIDTH, default 16, meaning data bits per frame (legal range 2..64).
REQ-002 SHALL have port fast_clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port serial_valid, input, 1, frame qualifier; high for the whole frame, low between frames.
REQ-005 SHALL have port serial_in, input, 1, serial data bit, LSB first, one bit per fast_clk cycle while serial_valid is high.
REQ-006 SHALL have port data_ack, input, 1, consumer acknowledge of the held word.
REQ-007 SHALL have port data_out, output, INPUT_WIDTH, assembled parallel word.
REQ-008 SHALL have port data_valid, output, 1, data_out holds an unacknowledged word.
REQ-009 SHALL have port serial_done, output, 1, one-cycle pulse on frame completion.
REQ-010 SHALL have port overrun, output, 1, sticky flag: a completed frame was dropped.
REQ-011 SHALL have port parity_err, output, 1, parity mismatch on the held word.

Function
REQ-012 SHALL implement states IDLE, SHIFT, (PARITY when REQ-029 applies), WAIT_LOW.
REQ-013 IDLE: a rising edge with serial_valid=1 SHALL sample serial_in as bit 0, set the bit counter to 1 and enter SHIFT.
REQ-014 SHIFT: each rising edge with serial_valid=1 SHALL store serial_in at index counter, then increment counter; counter is $clog2(INPUT_WIDTH)+1 bits wide and never wraps.
REQ-015 The edge sampling bit INPUT_WIDTH-1 SHALL complete the frame (macro off) and enter WAIT_LOW.
REQ-016 On completion, data_out, data_valid=1 and serial_done=1 SHALL be visible in the cycle after the last bit is sampled; latency one cycle.
REQ-017 serial_done SHALL be high for exactly one cycle per completed frame, including dropped frames.
REQ-018 serial_valid low in SHIFT or PARITY SHALL abort the frame: partial bits discarded, counter cleared, return to IDLE, no serial_done, data_out/data_valid unchanged.
REQ-019 WAIT_LOW SHALL ignore serial_in and return to IDLE on the first edge with serial_valid=0; the emitter holds its qualifier beyond the frame, and those cycles are not a new frame.
REQ-020 data_out SHALL remain stable while data_valid=1; data_valid SHALL clear on the edge sampling data_ack=1.
REQ-021 data_ack while data_valid=0 SHALL be ignored.
REQ-022 A frame completing while data_valid=1 with data_ack=0 SHALL be dropped: data_out keeps the old word, overrun=1.
REQ-023 Completion on the same edge as data_ack=1 SHALL load the new word, keep data_valid=1 and not set overrun.
REQ-024 overrun SHALL stay high until the edge sampling data_ack=1, or until reset.

Reset
REQ-025 reset low SHALL immediately, without a clock, force IDLE, counter=0, shift register=0.
REQ-026 reset low SHALL immediately force data_out=0, data_valid=0, serial_done=0, overrun=0 and parity_err=0.
REQ-027 Reset asserted mid-frame SHALL discard the frame; after release, the first serial_valid=1 edge starts a new frame at bit 0.
REQ-028 Release SHALL be synchronised to fast_clk; the first edge after release may already sample bit 0.

Configuration
REQ-029 With macro RX_PARITY_CHECK_EN defined, the frame SHALL be INPUT_WIDTH data bits plus one even-parity bit sampled in PARITY.
REQ-030 With RX_PARITY_CHECK_EN, completion SHALL occur on the parity-bit edge; parity_err SHALL be loaded with data_out (1 when XOR of data and parity bit is 1); the word is still delivered.
REQ-031 With RX_PARITY_CHECK_EN, parity_err SHALL clear with data_valid.
REQ-032 Without RX_PARITY_CHECK_EN, the PARITY state SHALL be absent and parity_err SHALL be constant 0.

Verification (INPUT_WIDTH=16)
REQ-033 0xA5C3 sent LSB first over 16 cycles, serial_valid then held 4 extra cycles -> data_out=0xA5C3 with data_valid=1 and one-cycle serial_done in the cycle after bit 15; no second frame.
REQ-034 serial_valid dropped after bit 7 of 0x1234, then 0xBEEF sent -> only 0xBEEF delivered, one serial_done.
REQ-035 0x1111 then 0x2222 without ack -> data_out=0x1111, overrun=1; ack -> data_valid=0, overrun=0.
REQ-036 data_ack on the completion edge of 0x3333 while 0x1111 is held -> data_out=0x3333, data_valid=1, overrun=0.
REQ-037 reset pulsed low mid-cycle at bit 9 -> all outputs 0 at once; next frame 0x00FF received correctly.
REQ-038 With RX_PARITY_CHECK_EN: 0x0001 with parity bit 1 -> parity_err=0; with parity bit 0 -> parity_err=1, data_out=0x0001.
